// File: rtl/regbus_pkg.sv
// Shared types and helpers for the register-bank bus initiator.
`default_nettype none
package regbus_pkg;

  localparam int MERGE_W = 64;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RMW   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Wide enough for any supported DW; callers zero-extend and truncate.
  function automatic logic [MERGE_W-1:0] rmw_merge(input logic [MERGE_W-1:0] old,
                                                   input logic [MERGE_W-1:0] wdata,
                                                   input logic [MERGE_W-1:0] mask);
    return (old & ~mask) | (wdata & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regbus_master.sv
// Register-bank bus initiator: one outstanding host command, executed as
// single-cycle read/write bus accesses, answered with one response.
`default_nettype none
module regbus_master
  import regbus_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [DW-1:0] cmd_mask,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [15:0]   txn_count,
  output logic          bus_sel,
  output logic          bus_wr,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  state_e        state;
  op_e           op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mask_q;
  logic [DW-1:0] old_q;

  assign cmd_ready = rstn && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      old_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
      bus_sel   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            mask_q  <= cmd_mask;
            // Bus outputs are registered, so the access is launched here.
            case (op_e'(cmd_op))
              OP_READ: begin
                bus_sel  <= 1'b1;
                bus_wr   <= 1'b0;
                bus_addr <= cmd_addr;
                state    <= ST_RD;
              end
              OP_WRITE: begin
                bus_sel   <= 1'b1;
                bus_wr    <= 1'b1;
                bus_addr  <= cmd_addr;
                bus_wdata <= cmd_wdata;
                state     <= ST_WR;
              end
              OP_RMW: begin
                bus_sel  <= 1'b1;
                bus_wr   <= 1'b0;
                bus_addr <= cmd_addr;
                state    <= ST_RMW_RD;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
                state     <= ST_RESP;
              end
            endcase
          end
        end
        ST_RD: begin
          bus_sel   <= 1'b0;
          bus_addr  <= '0;
          rsp_rdata <= bus_rdata;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_WR: begin
          bus_sel   <= 1'b0;
          bus_wr    <= 1'b0;
          bus_addr  <= '0;
          bus_wdata <= '0;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RMW_RD: begin
          // Select stays high straight into the write half of the RMW.
          old_q     <= bus_rdata;
          bus_wr    <= 1'b1;
          bus_addr  <= addr_q;
          bus_wdata <= DW'(rmw_merge(MERGE_W'(bus_rdata), MERGE_W'(wdata_q),
                                     MERGE_W'(mask_q)));
          state     <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          bus_sel   <= 1'b0;
          bus_wr    <= 1'b0;
          bus_addr  <= '0;
          bus_wdata <= '0;
          rsp_rdata <= old_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            if (op_q != OP_RSVD && txn_count != 16'hFFFF)
              txn_count <= txn_count + 16'd1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbus_master.sv
// Directed, table-driven bench for regbus_master with a 4-entry slave model.
`default_nettype none
module tb_regbus_master;
  import regbus_pkg::*;

  localparam int AW = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, cmd_mask;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [15:0]   txn_count;
  logic          bus_sel, bus_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  regbus_master #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .txn_count(txn_count),
    .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // Slave register bank: combinational read, write on the clock edge.
  logic [DW-1:0] regs [4];
  logic          slave_clr = 1'b1;
  assign bus_rdata = (bus_sel && !bus_wr) ? regs[bus_addr] : '0;
  always @(posedge clk) begin
    if (slave_clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (bus_sel && bus_wr) begin
      regs[bus_addr] <= bus_wdata;
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mask;
    logic [DW-1:0] exp_wr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs [11];

  // Entered and left at a falling edge with the DUT idle.
  task automatic do_cmd(input vec_t v, input int hold);
    int  lat;
    logic exp_sel, exp_wen;
    lat = (v.op == OP_RSVD) ? 1 : (v.op == OP_RMW) ? 3 : 2;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_mask = v.mask;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = OP_WRITE; cmd_addr = '0;
    cmd_wdata = 16'hDEAD; cmd_mask = 16'hFFFF;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      exp_sel = ((v.op == OP_READ || v.op == OP_WRITE) && k == 1) ||
                (v.op == OP_RMW && k <= 2);
      exp_wen = (v.op == OP_WRITE && k == 1) || (v.op == OP_RMW && k == 2);
      check("bus_sel", bus_sel, exp_sel);
      check("bus_wr", bus_wr, exp_wen);
      if (exp_sel) check("bus_addr", bus_addr, v.addr);
      if (exp_wen) check("bus_wdata", bus_wdata, v.exp_wr);
      check("rsp_valid_timing", rsp_valid, (k == lat));
      check("cmd_ready_busy", cmd_ready, 0);
    end
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", rsp_err, v.exp_err);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_bus_sel", bus_sel, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (!v.exp_err) exp_txn++;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
    check("txn_count", txn_count, exp_txn);
    check("bus_sel_after_hs", bus_sel, 0);
  endtask

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_wdata = '0; cmd_mask = '0; rsp_ready = 1'b0;

    vecs[0]  = '{OP_WRITE, 2'd2, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{OP_READ,  2'd2, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{OP_RMW,   2'd2, 16'h1234, 16'h00FF, 16'hBE34, 16'hBEEF, 1'b0};
    vecs[3]  = '{OP_READ,  2'd2, 16'h0000, 16'h0000, 16'h0000, 16'hBE34, 1'b0};
    vecs[4]  = '{OP_RSVD,  2'd1, 16'h1111, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    vecs[5]  = '{OP_WRITE, 2'd0, 16'h5A5A, 16'h0000, 16'h5A5A, 16'h0000, 1'b0};
    vecs[6]  = '{OP_WRITE, 2'd3, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    vecs[7]  = '{OP_RMW,   2'd3, 16'h0000, 16'hFF00, 16'h00FF, 16'hFFFF, 1'b0};
    vecs[8]  = '{OP_READ,  2'd3, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 1'b0};
    vecs[9]  = '{OP_RMW,   2'd0, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0};
    vecs[10] = '{OP_READ,  2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_txn_count", txn_count, 0);
    slave_clr = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("idle_bus_wdata", bus_wdata, 0);

    for (int i = 0; i < 11; i++) do_cmd(vecs[i], 0);

    // Host stalls the response; the held read must stay stable.
    do_cmd('{OP_READ, 2'd2, 16'h0, 16'h0, 16'h0, 16'hBE34, 1'b0}, 5);

    // Reset lands while the RMW read cycle is on the bus.
    cmd_valid = 1'b1; cmd_op = OP_RMW; cmd_addr = 2'd1;
    cmd_wdata = 16'h1234; cmd_mask = 16'hFFFF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_sel", bus_sel, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_sel", bus_sel, 0);
    check("mid_rst_wr", bus_wr, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_wdata", bus_wdata, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_txn", txn_count, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    rstn = 1'b1;
    exp_txn = 0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_sel", bus_sel, 0);
    check("post_rst_no_write", regs[1], 0);
    do_cmd('{OP_WRITE, 2'd1, 16'h7777, 16'h0, 16'h7777, 16'h0, 1'b0}, 0);
    do_cmd('{OP_READ, 2'd1, 16'h0, 16'h0, 16'h0, 16'h7777, 1'b0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
